// File: rtl/pdm_tx_pkg.sv
// Shared audio definitions for the PDM playback and capture paths:
// clock plan, default PCM width, oversampling ratio and transmitter state encoding.
package pdm_tx_pkg;

   localparam int PCM_WIDTH         = 16;
   localparam int SYS_CLK_HZ        = 100_000_000;
   localparam int PDM_BIT_HZ        = 1_000_000;
   localparam int DEFAULT_DIV_COUNT = SYS_CLK_HZ / PDM_BIT_HZ;
   localparam int DEFAULT_OSR       = 64;
   localparam int STATS_WIDTH       = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] value);
      return (&value) ? value : value + STATS_WIDTH'(1);
   endfunction

endpackage

// File: rtl/pdm_tick_gen.sv
// PDM bit-rate clock enable: one-cycle tick every DIV_COUNT system clocks.
// Counter is held at zero while clear is high, so the first tick after release is DIV_COUNT clocks later.
module pdm_tick_gen
   import pdm_tx_pkg::*;
#(
   parameter int DIV_COUNT = DEFAULT_DIV_COUNT
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int             CW   = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
   localparam logic [CW-1:0]  LAST = CW'(DIV_COUNT - 1);

   logic [CW-1:0] div_cnt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (clear || div_cnt == LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

   // The counter may still be mid-count on the first cleared cycle; never tick while cleared.
   assign tick = !clear && (div_cnt == LAST);

endmodule

// File: rtl/pdm_tx.sv
// PDM playback transmitter: first-order sigma-delta modulator fed by a two-deep sample buffer.
// Optional underrun statistics counter is enabled by defining PDM_TX_STATS_EN.
module pdm_tx
   import pdm_tx_pkg::*;
#(
   parameter int WIDTH     = PCM_WIDTH,
   parameter int DIV_COUNT = DEFAULT_DIV_COUNT,
   parameter int OSR       = DEFAULT_OSR
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] sample_in,
   input  logic             sample_valid,
   output logic             sample_ready,
   output logic             pdm_out,
   output logic             amp_en,
   output logic             bit_tick,
   output logic             underrun
`ifdef PDM_TX_STATS_EN
   ,
   output logic [STATS_WIDTH-1:0] underrun_count
`endif
);

   localparam int               BW       = $clog2(OSR);
   localparam logic [BW-1:0]    BIT_LAST = BW'(OSR - 1);
   localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] cur;
   logic [WIDTH-1:0] nxt;
   logic             nxt_full;
   logic [WIDTH-1:0] acc;
   logic [BW-1:0]    bit_cnt;
   logic [WIDTH:0]   acc_sum;
   logic             running;
   logic             xfer;
   logic             slot_end;
   logic             starve;

   pdm_tick_gen #(
      .DIV_COUNT (DIV_COUNT)
   ) tick_gen (
      .clock (clock),
      .reset (reset),
      .clear (state == IDLE),
      .tick  (bit_tick)
   );

   assign running      = (state != IDLE);
   assign amp_en       = running;
   assign sample_ready = running && !nxt_full;
   assign xfer         = sample_valid && sample_ready;
   assign slot_end     = (state == RUN) && enable && bit_tick && (bit_cnt == BIT_LAST);
   // Slot ends with nothing to play next: neither buffered nor arriving this cycle.
   assign starve       = slot_end && !nxt_full && !xfer;

   // Offset-binary view of cur: inverting the sign bit maps signed PCM onto 0..2^WIDTH-1.
   assign acc_sum = {1'b0, acc} + {1'b0, cur ^ MSB_MASK};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (enable) state_next = WAIT;
         WAIT: begin
            if (!enable)   state_next = IDLE;
            else if (xfer) state_next = RUN;
         end
         RUN:  if (!enable) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur      <= '0;
         nxt      <= '0;
         nxt_full <= 1'b0;
         acc      <= '0;
         bit_cnt  <= '0;
         pdm_out  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         underrun <= 1'b0;
         if (state == IDLE || !enable) begin
            // Stopping abandons any partial sample; the next start modulates from acc = 0.
            cur      <= '0;
            nxt      <= '0;
            nxt_full <= 1'b0;
            acc      <= '0;
            bit_cnt  <= '0;
            pdm_out  <= 1'b0;
         end else if (state == WAIT) begin
            if (xfer) begin
               cur     <= sample_in;
               bit_cnt <= '0;
            end
         end else begin
            if (bit_tick) begin
               acc     <= acc_sum[WIDTH-1:0];
               pdm_out <= acc_sum[WIDTH];
            end
            if (slot_end) begin
               bit_cnt <= '0;
               if (nxt_full) begin
                  cur      <= nxt;
                  nxt_full <= 1'b0;
               end else if (xfer) begin
                  cur <= sample_in;
               end else begin
                  cur      <= '0;
                  underrun <= 1'b1;
               end
            end else begin
               if (bit_tick) begin
                  bit_cnt <= bit_cnt + BW'(1);
               end
               if (xfer) begin
                  nxt      <= sample_in;
                  nxt_full <= 1'b1;
               end
            end
         end
      end
   end

`ifdef PDM_TX_STATS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         underrun_count <= '0;
      end else if (state == IDLE && enable) begin
         underrun_count <= '0;
      end else if (starve) begin
         underrun_count <= sat_inc(underrun_count);
      end
   end
`endif

endmodule

// File: doc/pdm_tx.md
Name: pdm_tx

Overview:
PDM playback transmitter, the output-side counterpart of the microphone-clock path.
- Accepts signed PCM samples over a valid/ready handshake.
- Runs a first-order sigma-delta modulator at a bit rate derived from the 100 MHz system clock by an internal clock-enable divider.
- Drives a 1-bit PDM stream and the amplifier enable.
- Sits between the playback sample source (memory reader) and the board audio amplifier pin.

Parameters:
- WIDTH, 16, PCM sample width, signed two's complement.
- DIV_COUNT, 100, system clocks per PDM bit (100 MHz -> 1 MHz); must be >= 2.
- OSR, 64, PDM bits per PCM sample; must be >= 2.

Ports:
- clock  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-high.
- enable  in  1  level; 1 = play, 0 = stop and idle outputs.
- sample_in  in  WIDTH  signed PCM sample.
- sample_valid  in  1  sample_in valid.
- sample_ready  out  1  block can accept a sample this cycle.
- pdm_out  out  1  PDM bit to amplifier.
- amp_en  out  1  amplifier shutdown-bar; 1 while running.
- bit_tick  out  1  one-clock pulse per PDM bit period.
- underrun  out  1  one-clock pulse when a sample slot starts with no sample buffered.

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, all counters 0, accumulator 0, both buffers empty.
- Tick divider:
  - div_cnt counts 0..DIV_COUNT-1 only while state != IDLE; held at 0 in IDLE.
  - bit_tick = 1 for exactly one clock when div_cnt == DIV_COUNT-1, then div_cnt wraps to 0.
- Buffering: two registers, cur (sample being modulated) and nxt (one-entry skid).
  - sample_ready = 1 iff state != IDLE and nxt is empty.
  - Transfer occurs when sample_valid && sample_ready.
  - In WAIT the transferred sample loads cur directly; in RUN it loads nxt.
- States:
  - IDLE: sample_ready = 0, amp_en = 0, pdm_out = 0. enable=1 -> WAIT next clock.
  - WAIT: amp_en = 1, pdm_out = 0, no modulation. A transfer loads cur, sets bit_cnt = 0, -> RUN.
  - RUN: amp_en = 1. On each bit_tick, the modulator updates and bit_cnt increments.
  - enable=0 in WAIT or RUN -> IDLE next clock, buffers flushed, accumulator cleared. This may occur mid-sample; no drain.
- Modulator (on bit_tick in RUN only):
  - u = cur with its MSB inverted (offset binary, WIDTH bits).
  - acc_sum = {1'b0, acc} + u, WIDTH+1 bits.
  - acc <= acc_sum[WIDTH-1:0]; pdm_out <= acc_sum[WIDTH].
  - pdm_out is registered: it changes on the clock edge where bit_tick is high and holds until the next tick.
  - Long-run ones density = u / 2^WIDTH.
- Sample slot end (bit_tick with bit_cnt == OSR-1):
  - bit_cnt -> 0.
  - If nxt is full: cur <= nxt, nxt empty.
  - Else: cur <= 0 (midscale), underrun pulses 1 clock, remain in RUN.
  - A transfer into nxt in the same cycle as the slot end is legal: nxt is vacated first, so the new sample goes to cur directly (treated as full -> no underrun).
- Reset mid-operation: immediate return to reset values; no partial sample is retained.

Optional Feature:
Macro PDM_TX_STATS_EN.
- Defined: adds output underrun_count, 16 bits.
  - Increments on each underrun pulse and saturates at 0xFFFF.
  - Cleared by reset and on the IDLE->WAIT transition.
- Undefined: port and counter absent; underrun pulse unchanged.

Decomposition:
- Shared audio package: PCM_WIDTH = 16, SYS_CLK_HZ = 100_000_000, PDM_BIT_HZ = 1_000_000, default OSR = 64, state enum {IDLE, WAIT, RUN}.
- One natural sub-module, pdm_tick_gen: divider producing bit_tick, with clear input driven by state == IDLE. Reusable by the capture path.

Test Plan:
- Reset: assert reset mid-RUN -> all outputs 0 within the same cycle (async); after release with enable=0, outputs stay 0 and no bit_tick.
- Midscale: enable=1, feed 0x0000 continuously -> pdm_out alternates 1,0,1,0 starting 1 on the second tick from acc=0; 32 ones per 64-bit slot; bit_tick every 100 clocks.
- Full-scale: feed 0x7FFF, then 0x8000 -> 0x7FFF yields 64 ones per slot except one possible 0 per 65536 bits; 0x8000 yields all zeros.
- Back-pressure:
  - Hold sample_valid=1 with distinct values -> sample_ready drops after nxt fills.
  - One transfer per 64 ticks thereafter; samples modulate in order, none lost or duplicated.
- Underrun: supply one sample then stop -> after 64 ticks, underrun pulses once per slot; density reverts to 50%. With PDM_TX_STATS_EN, underrun_count increments per slot.
- Stop mid-sample: drop enable at bit 20 of a slot -> IDLE next clock, amp_en=0, pdm_out=0, sample_ready=0. Re-enable -> WAIT, then the first sample modulates from acc=0.
